// File: rtl/ntt_bf_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_bf_ctrl
//
// Sequencer for a single radix-2 compact butterfly shared between the forward
// (Cooley-Tukey) and inverse (Gentleman-Sande) NTT. It walks all LOGN stages of
// an N-point in-place transform and issues one butterfly per cycle. For each
// butterfly it produces the operand address pair, the twiddle ROM address and
// the butterfly mode select. After the fixed read+compute latency it returns
// the same address pair as a write-back strobe. Between stages the issue
// stream pauses for WB_LAT cycles, so no read can overtake a pending write.
//
// Parameters
//   LOGN    log2 of the transform size N (N/2 butterflies per stage)
//   WB_LAT  cycles from rd_en_o to the matching wr_en_o (>= 1)
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      one-cycle request, accepted only when idle
//   mode_i       sampled with start_i: 0 = forward (CT), 1 = inverse (GS)
//   busy_o       high from the cycle after an accepted start through done
//   done_o       one-cycle pulse coincident with the final wr_en_o
//   rd_en_o      butterfly issue strobe
//   rd_addr_u_o  upper operand address (base + j)
//   rd_addr_v_o  lower operand address (base + j + len)
//   tw_addr_o    {mode, k}: twiddle ROM address
//   bf_sel_o     butterfly mode select (latched mode)
//   wr_en_o      write-back strobe, rd_en_o delayed by WB_LAT cycles
//   wr_addr_u_o  rd_addr_u_o delayed by WB_LAT cycles
//   wr_addr_v_o  rd_addr_v_o delayed by WB_LAT cycles
//   cycle_cnt_o  busy-cycle performance counter
//
// Build option
//   NTT_CTRL_PERF_EN  when defined, cycle_cnt_o counts busy cycles of the
//                     most recent run (cleared on accepted start, saturating).
//                     When undefined, cycle_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module ntt_bf_ctrl #(
  parameter int LOGN   = 8,
  parameter int WB_LAT = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            mode_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_en_o,
  output logic [LOGN-1:0] rd_addr_u_o,
  output logic [LOGN-1:0] rd_addr_v_o,
  output logic [LOGN:0]   tw_addr_o,
  output logic            bf_sel_o,
  output logic            wr_en_o,
  output logic [LOGN-1:0] wr_addr_u_o,
  output logic [LOGN-1:0] wr_addr_v_o,
  output logic [15:0]     cycle_cnt_o
);

  localparam int SW = $clog2(LOGN + 1);
  localparam int FW = $clog2(WB_LAT + 1);
  localparam int DW = 2 * LOGN + 1;

  localparam logic [SW-1:0]   LAST_STAGE  = SW'(LOGN - 1);
  localparam logic [SW-1:0]   STAGE_ONE   = SW'(1);
  localparam logic [FW-1:0]   FL_ONE      = FW'(1);
  // Between stages the pause is WB_LAT cycles; after the final stage the
  // last pause cycle is the DONE cycle itself, so the flush is one shorter.
  localparam logic [FW-1:0]   FL_MID_LAST = FW'(WB_LAT - 1);
  localparam logic [FW-1:0]   FL_END_LAST = FW'((WB_LAT >= 2) ? (WB_LAT - 2) : 0);
  localparam bit              LAT_ONE     = (WB_LAT == 1);
  localparam logic [LOGN-1:0] ONE_A       = LOGN'(1);
  localparam logic [LOGN-1:0] ZERO_A      = LOGN'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Butterfly span of a stage: forward halves from N/2, inverse doubles from 1.
  function automatic logic [LOGN-1:0] half_span(input logic [SW-1:0] stage,
                                                input logic          inv);
    logic [LOGN-1:0] span;
    if (inv) begin
      span = ONE_A << stage;
    end else begin
      span = ONE_A << (LAST_STAGE - stage);
    end
    return span;
  endfunction

  state_e          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [LOGN-1:0] base_q, base_d;
  logic [LOGN-1:0] j_q, j_d;
  logic [LOGN-1:0] k_q, k_d;
  logic [FW-1:0]   fl_q, fl_d;
  logic            mode_q, mode_d;

  logic            busy_q;
  logic            done_q;
  logic            rd_en_q;
  logic [LOGN-1:0] rd_addr_u_q;
  logic [LOGN-1:0] rd_addr_v_q;
  logic [LOGN:0]   tw_addr_q;

  logic [LOGN-1:0] len_s;
  logic            last_j_s;
  logic            last_grp_s;
  logic            stage_end_s;
  logic [LOGN-1:0] len_d_s;
  logic [LOGN-1:0] u_d_s;
  logic [LOGN-1:0] v_d_s;

  logic [DW-1:0]   dly_q [WB_LAT];

  // Position of the butterfly currently issued within its group and stage.
  // The group stride 2*len wraps to zero after the last group of a stage.
  assign len_s       = half_span(stage_q, mode_q);
  assign last_j_s    = (j_q == (len_s - ONE_A));
  assign last_grp_s  = ((base_q + (len_s << 1)) == ZERO_A);
  assign stage_end_s = last_j_s & last_grp_s;

  // Next-state and counter-advance logic of the sequencer.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    base_d  = base_q;
    j_d     = j_q;
    k_d     = k_q;
    fl_d    = fl_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          stage_d = '0;
          base_d  = ZERO_A;
          j_d     = ZERO_A;
          k_d     = ONE_A;
          mode_d  = mode_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stage_end_s) begin
          // Prepare the first butterfly of the next stage during the pause.
          base_d = ZERO_A;
          j_d    = ZERO_A;
          k_d    = k_q + ONE_A;
          fl_d   = '0;
          if ((stage_q == LAST_STAGE) && LAT_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FLUSH;
          end
        end else if (last_j_s) begin
          j_d    = ZERO_A;
          base_d = base_q + (len_s << 1);
          k_d    = k_q + ONE_A;
        end else begin
          j_d = j_q + ONE_A;
        end
      end
      S_FLUSH: begin
        if (stage_q == LAST_STAGE) begin
          if (fl_q == FL_END_LAST) begin
            state_d = S_DONE;
          end else begin
            fl_d = fl_q + FL_ONE;
          end
        end else begin
          if (fl_q == FL_MID_LAST) begin
            state_d = S_RUN;
            stage_d = stage_q + STAGE_ONE;
          end else begin
            fl_d = fl_q + FL_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Issue-side outputs are registered from the next-cycle counter values.
  assign len_d_s = half_span(stage_d, mode_d);
  assign u_d_s   = base_d + j_d;
  assign v_d_s   = u_d_s + len_d_s;

  // Sequencer state and registered issue outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      base_q      <= ZERO_A;
      j_q         <= ZERO_A;
      k_q         <= ZERO_A;
      fl_q        <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_u_q <= ZERO_A;
      rd_addr_v_q <= ZERO_A;
      tw_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      base_q      <= base_d;
      j_q         <= j_d;
      k_q         <= k_d;
      fl_q        <= fl_d;
      mode_q      <= mode_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      rd_en_q     <= (state_d == S_RUN);
      rd_addr_u_q <= u_d_s;
      rd_addr_v_q <= v_d_s;
      tw_addr_q   <= {mode_d, k_d};
    end
  end

  // Write-back delay line: {strobe, u, v} shifted WB_LAT cycles, cleared on
  // reset so an aborted run produces no stray writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < WB_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= {rd_en_q, rd_addr_u_q, rd_addr_v_q};
      for (int i = 1; i < WB_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_u_o = rd_addr_u_q;
  assign rd_addr_v_o = rd_addr_v_q;
  assign tw_addr_o   = tw_addr_q;
  assign bf_sel_o    = mode_q;
  assign wr_en_o     = dly_q[WB_LAT-1][DW-1];
  assign wr_addr_u_o = dly_q[WB_LAT-1][2*LOGN-1:LOGN];
  assign wr_addr_v_o = dly_q[WB_LAT-1][LOGN-1:0];

`ifdef NTT_CTRL_PERF_EN
  logic [15:0] cnt_q;

  // Busy-cycle counter: cleared on accepted start, saturates, holds when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'h0000;
    end else if ((state_q == S_IDLE) && start_i) begin
      cnt_q <= 16'h0000;
    end else if (busy_q && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'h0001;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cycle_cnt_o = cnt_q;
`else
  assign cycle_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ntt_bf_ctrl.sv
module tb_ntt_bf_ctrl;

  localparam int LOGN    = 3;
  localparam int WB_LAT  = 2;
  localparam int N       = 1 << LOGN;
  localparam int RUN_LEN = LOGN * (N / 2 + WB_LAT);

  logic            clk;
  logic            rst_i;
  logic            start_i;
  logic            mode_i;
  logic            busy_o;
  logic            done_o;
  logic            rd_en_o;
  logic [LOGN-1:0] rd_addr_u_o;
  logic [LOGN-1:0] rd_addr_v_o;
  logic [LOGN:0]   tw_addr_o;
  logic            bf_sel_o;
  logic            wr_en_o;
  logic [LOGN-1:0] wr_addr_u_o;
  logic [LOGN-1:0] wr_addr_v_o;
  logic [15:0]     cycle_cnt_o;

  ntt_bf_ctrl #(.LOGN(LOGN), .WB_LAT(WB_LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_u_o (rd_addr_u_o),
    .rd_addr_v_o (rd_addr_v_o),
    .tw_addr_o   (tw_addr_o),
    .bf_sel_o    (bf_sel_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_u_o (wr_addr_u_o),
    .wr_addr_v_o (wr_addr_v_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int u;
    int v;
    int tw;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  ev_t hist[$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  int free_from   = 0;
  int busy_from   = 1;
  int busy_to     = 0;
  int exp_bfsel   = 0;
  int perf_start  = -1;
  int perf_done   = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int t);
`ifdef NTT_CTRL_PERF_EN
    int m;
    if (perf_start < 0) return 0;
    m = (t - 1 < perf_done) ? (t - 1) : perf_done;
    return m - perf_start;
`else
    return 0;
`endif
  endfunction

  // Reference schedule of one transform computed straight from the stage rules.
  task automatic model_start(input int c, input int m);
    int  t;
    int  k;
    int  len;
    ev_t e;
    t = c + 1;
    k = 1;
    for (int s = 0; s < LOGN; s++) begin
      len = (m != 0) ? (1 << s) : (N >> (s + 1));
      for (int b = 0; b < N; b += 2 * len) begin
        for (int j = 0; j < len; j++) begin
          e.cyc = t;
          e.u   = b + j;
          e.v   = b + j + len;
          e.tw  = (m << LOGN) | k;
          rd_q.push_back(e);
          e.cyc = t + WB_LAT;
          wr_q.push_back(e);
          t++;
        end
        k++;
      end
      t += WB_LAT;
    end
    done_q.push_back(c + RUN_LEN);
  endtask

  // One cycle of stimulus; model bookkeeping applies from the next cycle on.
  task automatic tick(input logic s, input logic m, input logic r);
    int c;
    bit acc;
    c       = cyc;
    start_i = s;
    mode_i  = m;
    rst_i   = r;
    acc     = !r && s && (c >= free_from);
    @(posedge clk);
    #1;
    if (r) begin
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      hist.delete();
      free_from  = c + 1;
      if (busy_to > c) busy_to = c;
      exp_bfsel  = 0;
      perf_start = -1;
    end else if (acc) begin
      model_start(c, int'(m));
      busy_from  = c + 1;
      busy_to    = c + RUN_LEN;
      free_from  = c + RUN_LEN + 1;
      exp_bfsel  = int'(m);
      perf_start = c;
      perf_done  = c + RUN_LEN;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      int  t;
      int  hit;
      ev_t e;
      t = cyc;
      chk("busy", int'(busy_o), (t >= busy_from && t <= busy_to) ? 1 : 0);
      chk("bf_sel", int'(bf_sel_o), exp_bfsel);
      chk("cycle_cnt", int'(cycle_cnt_o), exp_cnt(t));

      while (hist.size() > 0 && (t - hist[0].cyc) > WB_LAT) hist.delete(0);
      if (rd_en_o) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = rd_q.pop_front();
          chk("rd_cycle", t, e.cyc);
          chk("rd_addr_u", int'(rd_addr_u_o), e.u);
          chk("rd_addr_v", int'(rd_addr_v_o), e.v);
          chk("tw_addr", int'(tw_addr_o), e.tw);
        end
        hit = 0;
        foreach (hist[i]) begin
          if (int'(rd_addr_u_o) == hist[i].u || int'(rd_addr_u_o) == hist[i].v ||
              int'(rd_addr_v_o) == hist[i].u || int'(rd_addr_v_o) == hist[i].v) hit = 1;
        end
        chk("raw_hazard", hit, 0);
        e.cyc = t;
        e.u   = int'(rd_addr_u_o);
        e.v   = int'(rd_addr_v_o);
        e.tw  = 0;
        hist.push_back(e);
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= t) begin
        chk("rd_missing", 0, 1);
        void'(rd_q.pop_front());
      end

      if (wr_en_o) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = wr_q.pop_front();
          chk("wr_cycle", t, e.cyc);
          chk("wr_addr_u", int'(wr_addr_u_o), e.u);
          chk("wr_addr_v", int'(wr_addr_v_o), e.v);
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= t) begin
        chk("wr_missing", 0, 1);
        void'(wr_q.pop_front());
      end

      if (done_o) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_cycle", t, done_q.pop_front());
        end
      end else if (done_q.size() > 0 && done_q[0] <= t) begin
        chk("done_missing", 0, 1);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    int stop_at;
    start_i = 1'b0;
    mode_i  = 1'b0;
    rst_i   = 1'b1;

    // Reset and reset-state check.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_rd_en", int'(rd_en_o), 0);
    chk("rst_wr_en", int'(wr_en_o), 0);
    chk("rst_bf_sel", int'(bf_sel_o), 0);
    chk("rst_rd_addr_u", int'(rd_addr_u_o), 0);
    chk("rst_rd_addr_v", int'(rd_addr_v_o), 0);
    chk("rst_tw_addr", int'(tw_addr_o), 0);
    chk("rst_wr_addr_u", int'(wr_addr_u_o), 0);
    chk("rst_wr_addr_v", int'(wr_addr_v_o), 0);
    chk("rst_cycle_cnt", int'(cycle_cnt_o), 0);
    mon_en = 1'b1;
    idle(2);

    // Forward run.
    tick(1'b1, 1'b0, 1'b0);
    idle(RUN_LEN + 2);

    // Inverse run; bf_sel must stay high while idle afterwards.
    tick(1'b1, 1'b1, 1'b0);
    idle(RUN_LEN + 4);

    // Starts during the run and in the done cycle are ignored.
    tick(1'b1, 1'b0, 1'b0);
    idle(4);
    tick(1'b1, 1'b1, 1'b0);
    idle(12);
    tick(1'b1, 1'b1, 1'b0);
    idle(3);

    // Reset mid-run aborts, then a clean restart.
    tick(1'b1, 1'b0, 1'b0);
    idle(8);
    tick(1'b0, 1'b0, 1'b1);
    idle(2);
    tick(1'b1, 1'b0, 1'b0);
    idle(RUN_LEN + 2);

    // Randomized runs with stray starts and an occasional abort.
    for (int run = 0; run < 10; run++) begin
      idle($urandom_range(0, 3));
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      stop_at = (run % 4 == 3) ? int'($urandom_range(2, RUN_LEN - 1)) : RUN_LEN + 1;
      for (int i = 1; i <= RUN_LEN; i++) begin
        if (i == stop_at) begin
          tick(1'b0, 1'b0, 1'b1);
          break;
        end
        tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    idle(RUN_LEN + 4);
    chk("rd_leftover", rd_q.size(), 0);
    chk("wr_leftover", wr_q.size(), 0);
    chk("done_leftover", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
